// File: rtl/jserial_pkg.sv
// Shared types and line-level constants for the jserial framed transmitter.
package jserial_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic SOUT_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    localparam int unsigned BAUD_CNT_W = 16;

endpackage

// File: rtl/jserial_tx_jbaud_tick.sv
// Bit-period timer: tick marks the last clock of each DIV-clock bit period,
// pre_tick marks the clock just before a tick so callers can register outputs for it.
module jbaud_tick
    import jserial_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick,
    output logic pre_tick
);

    localparam logic [BAUD_CNT_W-1:0] LAST = BAUD_CNT_W'(DIV - 1);
    localparam logic [BAUD_CNT_W-1:0] PRE  = (DIV > 1) ? BAUD_CNT_W'(DIV - 2) : '0;

    logic [BAUD_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = '0;
        if (en && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick     = en && (cnt_q == LAST);
    // With DIV=1 every clock is a boundary, so the next clock is always a tick.
    assign pre_tick = en && (cnt_q == PRE);

endmodule

// File: rtl/jserial_tx.sv
// Framed parallel-to-serial transmitter: start bit, WIDTH data bits, stop bit.
// Define JSERIAL_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module jserial_tx
    import jserial_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DIV       = 1,
    parameter int MSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    localparam int BCW = $clog2(WIDTH + 1);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
    logic             sout_q, sout_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef JSERIAL_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif

    logic baud_en, tick, pre_tick;

    assign baud_en = (state_q != IDLE);

    jbaud_tick #(.DIV(DIV)) u_baud (
        .clk      (clk),
        .rst      (rst),
        .en       (baud_en),
        .tick     (tick),
        .pre_tick (pre_tick)
    );

    function automatic logic [WIDTH-1:0] shift_next(input logic [WIDTH-1:0] v);
        return (MSB_FIRST != 0) ? (v << 1) : (v >> 1);
    endfunction

    function automatic logic head_bit(input logic [WIDTH-1:0] v);
        return (MSB_FIRST != 0) ? v[WIDTH-1] : v[0];
    endfunction

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        bit_cnt_d = bit_cnt_q;
        sout_d    = sout_q;
        ready_d   = ready_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
`ifdef JSERIAL_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (din_valid && ready_q) begin
                    state_d   = START;
                    sr_d      = din;
                    bit_cnt_d = '0;
                    sout_d    = START_BIT;
                    ready_d   = 1'b0;
                    busy_d    = 1'b1;
`ifdef JSERIAL_TX_PARITY_EN
                    parity_d  = ^din;
`endif
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                    sout_d  = head_bit(sr_q);
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_cnt_q == LAST_BIT) begin
`ifdef JSERIAL_TX_PARITY_EN
                        state_d = PARITY;
                        sout_d  = parity_q;
`else
                        state_d = STOP;
                        sout_d  = STOP_BIT;
`endif
                    end else begin
                        sr_d      = shift_next(sr_q);
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        sout_d    = head_bit(shift_next(sr_q));
                    end
                end
            end
`ifdef JSERIAL_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    state_d = STOP;
                    sout_d  = STOP_BIT;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    state_d = IDLE;
                    sout_d  = SOUT_IDLE;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                sout_d  = SOUT_IDLE;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
        // done is registered, so it is raised one clock ahead of the final stop clock.
        if ((state_d == STOP) && pre_tick) begin
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            bit_cnt_q <= '0;
            sout_q    <= SOUT_IDLE;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef JSERIAL_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
            sout_q    <= sout_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef JSERIAL_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign sout      = sout_q;
    assign din_ready = ready_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_jserial_tx.sv
// Scoreboard bench for jserial_tx: three instances (LSB-first/DIV=1, MSB-first/DIV=1, LSB-first/DIV=4).
module tb_jserial_tx;

    localparam int W = 8;
`ifdef JSERIAL_TX_PARITY_EN
    localparam int NB = W + 3;
`else
    localparam int NB = W + 2;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [W-1:0] din  [3];
    logic         vld  [3];
    logic         rdy  [3];
    logic         sout [3];
    logic         busy [3];
    logic         done [3];

    jserial_tx #(.WIDTH(W), .DIV(1), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .rst(rst), .din(din[0]), .din_valid(vld[0]), .din_ready(rdy[0]),
        .sout(sout[0]), .busy(busy[0]), .done(done[0]));

    jserial_tx #(.WIDTH(W), .DIV(1), .MSB_FIRST(1)) u_msb (
        .clk(clk), .rst(rst), .din(din[1]), .din_valid(vld[1]), .din_ready(rdy[1]),
        .sout(sout[1]), .busy(busy[1]), .done(done[1]));

    jserial_tx #(.WIDTH(W), .DIV(4), .MSB_FIRST(0)) u_div4 (
        .clk(clk), .rst(rst), .din(din[2]), .din_valid(vld[2]), .din_ready(rdy[2]),
        .sout(sout[2]), .busy(busy[2]), .done(done[2]));

    int total = 0;
    int bad   = 0;

    // Each entry is {sout, busy, din_ready, done} for one clock.
    logic [3:0] exp_q [$];

    localparam logic [3:0] IDLE_EXP = 4'b1010;

    function automatic logic [3:0] obs(input int d);
        return {sout[d], busy[d], rdy[d], done[d]};
    endfunction

    task automatic chk(input string tag, input logic [3:0] o, input logic [3:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s: sout/busy/rdy/done observed=%b expected=%b", tag, o, e);
        end
    endtask

    task automatic push_frame(input logic [W-1:0] w, input int dv, input bit msb);
        logic bits [$];
        bits.push_back(1'b0);
        for (int i = 0; i < W; i++) begin
            bits.push_back(msb ? w[W-1-i] : w[i]);
        end
`ifdef JSERIAL_TX_PARITY_EN
        bits.push_back(^w);
`endif
        bits.push_back(1'b1);
        for (int b = 0; b < bits.size(); b++) begin
            for (int k = 0; k < dv; k++) begin
                exp_q.push_back({bits[b], 1'b1, 1'b0, ((b == bits.size() - 1) && (k == dv - 1))});
            end
        end
        exp_q.push_back(IDLE_EXP);
    endtask

    task automatic pop_chk(input int d, input string tag, input int n);
        logic [3:0] e;
        total++;
        assert (exp_q.size() != 0) else begin
            bad++;
            $error("FAIL %s[%0d]: scoreboard observed=empty expected=entry", tag, n);
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk($sformatf("%s[%0d]", tag, n), obs(d), e);
        end
        @(posedge clk); #1;
    endtask

    task automatic send(input int d, input logic [W-1:0] w, input int dv, input bit msb,
                        input string tag);
        din[d] = w;
        vld[d] = 1'b1;
        chk({tag, "_accept"}, obs(d), IDLE_EXP);
        push_frame(w, dv, msb);
        @(posedge clk); #1;
        vld[d] = 1'b0;
        din[d] = ~w;
        for (int n = 0; n < NB * dv + 1; n++) begin
            pop_chk(d, tag, n);
        end
    endtask

    initial begin
        rst = 1'b0;
        for (int d = 0; d < 3; d++) begin
            din[d] = 8'hA5;
            vld[d] = 1'b1;
        end

        // Reset held with din_valid asserted
        repeat (2) begin
            @(posedge clk); #1;
            for (int d = 0; d < 3; d++) chk($sformatf("reset_%0d", d), obs(d), IDLE_EXP);
        end
        for (int d = 0; d < 3; d++) vld[d] = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        for (int d = 0; d < 3; d++) chk($sformatf("post_reset_%0d", d), obs(d), IDLE_EXP);

        send(0, 8'hA5, 1, 1'b0, "lsb_a5");
        send(1, 8'hA5, 1, 1'b1, "msb_a5");
        send(1, 8'h01, 1, 1'b1, "msb_01");
        send(2, 8'h3C, 4, 1'b0, "div4_3c");

        // Back-to-back with din_valid held high
        din[0] = 8'h00;
        vld[0] = 1'b1;
        chk("b2b_accept", obs(0), IDLE_EXP);
        push_frame(8'h00, 1, 1'b0);
        push_frame(8'hFF, 1, 1'b0);
        @(posedge clk); #1;
        din[0] = 8'hFF;
        for (int n = 0; n < NB + 1; n++) pop_chk(0, "b2b_first", n);
        vld[0] = 1'b0;
        for (int n = 0; n < NB + 1; n++) pop_chk(0, "b2b_second", n);

        // Mid-frame reset at data bit 3 of 0x55
        din[0] = 8'h55;
        vld[0] = 1'b1;
        chk("midrst_accept", obs(0), IDLE_EXP);
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b1100);
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b1100);
        exp_q.push_back(4'b0100);
        @(posedge clk); #1;
        vld[0] = 1'b0;
        for (int n = 0; n < 4; n++) pop_chk(0, "midrst_frame", n);
        chk("midrst_bit3", obs(0), exp_q.pop_front());
        rst = 1'b0;
        @(posedge clk); #1;
        chk("midrst_abort", obs(0), IDLE_EXP);
        rst = 1'b1;
        for (int n = 0; n < NB; n++) begin
            @(posedge clk); #1;
            chk($sformatf("midrst_quiet[%0d]", n), obs(0), IDLE_EXP);
        end

        send(0, 8'h07, 1, 1'b0, "lsb_07");

        chk("scoreboard_drained", {3'b000, exp_q.size() == 0}, 4'b0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
